// File: rtl/oam_scanner.sv
// Mode-2 OAM scanner: walks the Y/X bytes of all OAM entries and keeps up to
// MAX_SPRITES entries that intersect the latched scanline, in OAM order.
module oam_scanner #(
   parameter int MAX_SPRITES = 10,
   parameter int NUM_ENTRIES = 40
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] ly,
   input  logic       tall_sprites,
   input  logic [7:0] oam_data_in,
   output logic [7:0] oam_addr,
   output logic       oam_read_en,
   output logic       busy,
   output logic       done,
   output logic [3:0] sprite_count,
   input  logic [3:0] rd_index,
   output logic       rd_valid,
   output logic [7:0] rd_x,
   output logic [5:0] rd_oam_index,
   output logic [3:0] rd_row
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   localparam logic [6:0] LAST_CNT = 7'(2 * NUM_ENTRIES - 1);
   localparam logic [3:0] MAX_CNT  = 4'(MAX_SPRITES);

   state_t     state_q, state_d;
   logic [6:0] scan_cnt_q, scan_cnt_d;
   logic [7:0] oam_addr_q, oam_addr_d;
   logic       read_en_q, read_en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [3:0] count_q, count_d;
   logic [7:0] ly_q, ly_d;
   logic       tall_q, tall_d;
   logic [7:0] y_q, y_d;
   logic       prev_vld_q, prev_vld_d;
   logic       prev_p_q, prev_p_d;
   logic [5:0] prev_n_q, prev_n_d;

   logic [MAX_SPRITES-1:0][7:0] buf_x_q, buf_x_d;
   logic [MAX_SPRITES-1:0][5:0] buf_idx_q, buf_idx_d;
   logic [MAX_SPRITES-1:0][3:0] buf_row_q, buf_row_d;

   logic [8:0] line_w;
   logic [8:0] y_w;
   logic [8:0] height_w;
   logic       hit_w;
   logic [3:0] row_w;

   // Sprite vertical hit test in 9 bits so Y near 255 cannot wrap.
   always_comb begin
      line_w   = {1'b0, ly_q} + 9'd16;
      y_w      = {1'b0, y_q};
      height_w = tall_q ? 9'd16 : 9'd8;
      hit_w    = (line_w >= y_w) && (line_w < (y_w + height_w));
      row_w    = 4'(line_w - y_w);
   end

   always_comb begin
      state_d    = state_q;
      scan_cnt_d = scan_cnt_q;
      oam_addr_d = oam_addr_q;
      read_en_d  = read_en_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      count_d    = count_q;
      ly_d       = ly_q;
      tall_d     = tall_q;
      y_d        = y_q;
      buf_x_d    = buf_x_q;
      buf_idx_d  = buf_idx_q;
      buf_row_d  = buf_row_q;
      // Remember which byte was addressed this cycle; its data arrives next cycle.
      prev_vld_d = read_en_q;
      prev_p_d   = scan_cnt_q[0];
      prev_n_d   = scan_cnt_q[6:1];

      if (prev_vld_q) begin
         if (!prev_p_q) begin
            y_d = oam_data_in;
         end else if (hit_w && (count_q < MAX_CNT)) begin
            buf_x_d[count_q]   = oam_data_in;
            buf_idx_d[count_q] = prev_n_q;
            buf_row_d[count_q] = row_w;
            count_d            = count_q + 4'd1;
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               ly_d       = ly;
               tall_d     = tall_sprites;
               count_d    = 4'd0;
               scan_cnt_d = 7'd0;
               oam_addr_d = 8'h00;
               read_en_d  = 1'b1;
               busy_d     = 1'b1;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            if (scan_cnt_q == LAST_CNT) begin
               read_en_d  = 1'b0;
               oam_addr_d = 8'h00;
               state_d    = DRAIN;
            end else begin
               scan_cnt_d = scan_cnt_q + 7'd1;
               oam_addr_d = {scan_cnt_d[6:1], 1'b0, scan_cnt_d[0]};
            end
         end
         DRAIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         scan_cnt_q <= 7'd0;
         oam_addr_q <= 8'h00;
         read_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= 4'd0;
         ly_q       <= 8'h00;
         tall_q     <= 1'b0;
         y_q        <= 8'h00;
         prev_vld_q <= 1'b0;
         prev_p_q   <= 1'b0;
         prev_n_q   <= 6'd0;
         buf_x_q    <= '0;
         buf_idx_q  <= '0;
         buf_row_q  <= '0;
      end else begin
         state_q    <= state_d;
         scan_cnt_q <= scan_cnt_d;
         oam_addr_q <= oam_addr_d;
         read_en_q  <= read_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
         ly_q       <= ly_d;
         tall_q     <= tall_d;
         y_q        <= y_d;
         prev_vld_q <= prev_vld_d;
         prev_p_q   <= prev_p_d;
         prev_n_q   <= prev_n_d;
         buf_x_q    <= buf_x_d;
         buf_idx_q  <= buf_idx_d;
         buf_row_q  <= buf_row_d;
      end
   end

   // Fetcher read port; entries beyond the live count read as zero.
   always_comb begin
      rd_valid     = (rd_index < count_q);
      rd_x         = 8'h00;
      rd_oam_index = 6'd0;
      rd_row       = 4'd0;
      if (rd_valid) begin
         rd_x         = buf_x_q[rd_index];
         rd_oam_index = buf_idx_q[rd_index];
         rd_row       = buf_row_q[rd_index];
      end
   end

   assign oam_addr     = oam_addr_q;
   assign oam_read_en  = read_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign sprite_count = count_q;

endmodule

// File: tb/tb_oam_scanner.sv
// Scoreboard bench for oam_scanner: stimulus queues expected scan results,
// a negedge monitor checks the per-cycle trace and the result buffer on done.
module tb_oam_scanner;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] ly = 8'h00;
   logic       tall_sprites = 1'b0;
   logic [7:0] oam_data_in;
   logic [7:0] oam_addr;
   logic       oam_read_en;
   logic       busy;
   logic       done;
   logic [3:0] sprite_count;
   logic [3:0] rd_index;
   logic       rd_valid;
   logic [7:0] rd_x;
   logic [5:0] rd_oam_index;
   logic [3:0] rd_row;

   typedef struct packed {
      logic [3:0]       count;
      logic [9:0][7:0]  x;
      logic [9:0][5:0]  idx;
      logic [9:0][3:0]  row;
   } exp_t;

   exp_t       sb_q[$];
   int         compared = 0;
   int         mismatched = 0;
   int         scan_c = 0;
   bit         tracking = 1'b0;
   logic [7:0] oam_mem [0:255];

   oam_scanner #(.MAX_SPRITES(10), .NUM_ENTRIES(40)) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start),
      .ly           (ly),
      .tall_sprites (tall_sprites),
      .oam_data_in  (oam_data_in),
      .oam_addr     (oam_addr),
      .oam_read_en  (oam_read_en),
      .busy         (busy),
      .done         (done),
      .sprite_count (sprite_count),
      .rd_index     (rd_index),
      .rd_valid     (rd_valid),
      .rd_x         (rd_x),
      .rd_oam_index (rd_oam_index),
      .rd_row       (rd_row)
   );

   always #20 clock = ~clock;

   // Synchronous OAM: data valid the cycle after the address.
   always @(posedge clock) oam_data_in <= oam_mem[oam_addr];

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (scan cycle %0d)", name, actual, expected, scan_c);
      end
   endtask

   task automatic clearOam();
      for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;
   endtask

   task automatic setEntry(input int n, input logic [7:0] y, input logic [7:0] x);
      oam_mem[4*n]     = y;
      oam_mem[4*n + 1] = x;
   endtask

   task automatic applyStimulus(input logic [7:0] ly_v, input bit tall_v, input bit push, input exp_t e);
      ly           = ly_v;
      tall_sprites = tall_v;
      start        = 1'b1;
      if (push) sb_q.push_back(e);
      @(posedge clock);
      #1;
      start    = 1'b0;
      scan_c   = 1;
      tracking = 1'b1;
   endtask

   task automatic waitDone();
      bit seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge clock);
         #1;
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL done_timeout: got no done pulse, expected one within 200 cycles");
      end
   endtask

   task automatic waitScanCycle(input int target);
      for (int k = 0; k < 200 && scan_c < target; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic runScan(input logic [7:0] ly_v, input bit tall_v, input exp_t e);
      applyStimulus(ly_v, tall_v, 1'b1, e);
      waitDone();
      repeat (2) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Monitor: cycle trace relative to the accepted start, and buffer check on done.
   initial begin
      exp_t e;
      int   c;
      int   exp_addr;
      rd_index = 4'd0;
      forever begin
         @(negedge clock);
         c = scan_c;
         if (tracking) begin
            if (c >= 1 && c <= 80) begin
               exp_addr = ((c - 1) >> 1) * 4 + ((c - 1) & 1);
               checkOutput("busy_scan", busy, 1);
               checkOutput("read_en_scan", oam_read_en, 1);
               checkOutput("oam_addr", oam_addr, exp_addr);
               checkOutput("done_early", done, 0);
               if (c == 1) checkOutput("count_cleared", sprite_count, 0);
            end else if (c == 81) begin
               checkOutput("busy_drain", busy, 1);
               checkOutput("read_en_drain", oam_read_en, 0);
               checkOutput("oam_addr_drain", oam_addr, 0);
               checkOutput("done_early", done, 0);
            end else if (c == 82) begin
               checkOutput("done_cycle82", done, 1);
               checkOutput("busy_cycle82", busy, 0);
            end
         end
         if (done) begin
            if (sb_q.size() == 0) begin
               checkOutput("unexpected_done", done, 0);
            end else begin
               e = sb_q.pop_front();
               checkOutput("sprite_count", sprite_count, e.count);
               for (int i = 0; i < 16; i++) begin
                  rd_index = 4'(i);
                  #1;
                  if (i < int'(e.count)) begin
                     checkOutput($sformatf("rd_valid[%0d]", i), rd_valid, 1);
                     checkOutput($sformatf("rd_x[%0d]", i), rd_x, e.x[i]);
                     checkOutput($sformatf("rd_oam_index[%0d]", i), rd_oam_index, e.idx[i]);
                     checkOutput($sformatf("rd_row[%0d]", i), rd_row, e.row[i]);
                  end else begin
                     checkOutput($sformatf("rd_valid[%0d]", i), rd_valid, 0);
                     checkOutput($sformatf("rd_x_zero[%0d]", i), rd_x, 0);
                     checkOutput($sformatf("rd_oam_index_zero[%0d]", i), rd_oam_index, 0);
                     checkOutput($sformatf("rd_row_zero[%0d]", i), rd_row, 0);
                  end
               end
               rd_index = 4'd0;
            end
         end
         scan_c = scan_c + 1;
      end
   end

   initial begin
      exp_t e;
      clearOam();
      repeat (2) @(posedge clock);
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_read_en", oam_read_en, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_count", sprite_count, 0);
      checkOutput("reset_addr", oam_addr, 0);
      checkOutput("reset_rd_valid", rd_valid, 0);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      $display("[TB] empty OAM");
      e = '0;
      runScan(8'd0, 1'b0, e);

      $display("[TB] single sprite at entry 3");
      clearOam();
      setEntry(3, 8'h10, 8'h08);
      e = '0;
      e.count = 4'd1; e.x[0] = 8'h08; e.idx[0] = 6'd3; e.row[0] = 4'd0;
      runScan(8'd0, 1'b0, e);

      $display("[TB] twelve hits, ten kept");
      clearOam();
      for (int n = 0; n < 12; n++) setEntry(n, 8'h10, 8'(n));
      e = '0;
      e.count = 4'd10;
      for (int i = 0; i < 10; i++) begin
         e.x[i] = 8'(i); e.idx[i] = 6'(i); e.row[i] = 4'd5;
      end
      runScan(8'd5, 1'b0, e);

      $display("[TB] height boundaries");
      clearOam();
      setEntry(0, 8'h10, 8'h33);
      e = '0; e.count = 4'd1; e.x[0] = 8'h33; e.idx[0] = 6'd0; e.row[0] = 4'd7;
      runScan(8'd7, 1'b0, e);
      e = '0;
      runScan(8'd8, 1'b0, e);
      e = '0; e.count = 4'd1; e.x[0] = 8'h33; e.idx[0] = 6'd0; e.row[0] = 4'd12;
      runScan(8'd12, 1'b1, e);
      e = '0; e.count = 4'd1; e.x[0] = 8'h33; e.idx[0] = 6'd0; e.row[0] = 4'd15;
      runScan(8'd15, 1'b1, e);
      e = '0;
      runScan(8'd16, 1'b1, e);

      $display("[TB] start and ly change mid-scan are ignored");
      clearOam();
      setEntry(3, 8'h10, 8'h08);
      e = '0;
      e.count = 4'd1; e.x[0] = 8'h08; e.idx[0] = 6'd3; e.row[0] = 4'd0;
      applyStimulus(8'd0, 1'b0, 1'b1, e);
      waitScanCycle(40);
      ly = 8'd100;
      tall_sprites = 1'b1;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      waitDone();
      repeat (2) begin
         @(posedge clock);
         #1;
      end

      $display("[TB] reset mid-scan");
      clearOam();
      setEntry(0, 8'h10, 8'h11);
      e = '0;
      applyStimulus(8'd0, 1'b0, 1'b0, e);
      waitScanCycle(30);
      tracking = 1'b0;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_read_en", oam_read_en, 0);
      checkOutput("abort_count", sprite_count, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_addr", oam_addr, 0);
      checkOutput("abort_rd_valid", rd_valid, 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (2) begin
         @(posedge clock);
         #1;
      end

      $display("[TB] back-to-back start in done cycle");
      clearOam();
      setEntry(0, 8'h24, 8'h55);
      e = '0;
      applyStimulus(8'd0, 1'b0, 1'b1, e);
      waitDone();
      e = '0; e.count = 4'd1; e.x[0] = 8'h55; e.idx[0] = 6'd0; e.row[0] = 4'd0;
      applyStimulus(8'd20, 1'b0, 1'b1, e);
      waitDone();
      repeat (2) begin
         @(posedge clock);
         #1;
      end

      checkOutput("scoreboard_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/oam_scanner.md
Name: oam_scanner

Overview:
- PPU-side initiator on the OAM read port of the memory map: during mode 2 it walks all 40 OAM entries and selects the sprites that intersect the current scanline.
- Reads through the PPU port of the memory map. oam_addr drives ppu_addr[7:0], oam_read_en drives ppu_oam_read_en, and oam_data_in comes from ppu_data_out.
- Holds up to 10 selected sprites in OAM order in a small result buffer. The pixel fetcher reads this buffer during mode 3.

Parameters:
- MAX_SPRITES, 10, result buffer depth (per-line sprite limit).
- NUM_ENTRIES, 40, number of OAM entries scanned.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse at start of mode 2; sampled only in IDLE.
- ly  input  8  current scanline; latched on accepted start.
- tall_sprites  input  1  LCDC bit 2 (0 = 8 px, 1 = 16 px high); latched on accepted start.
- oam_data_in  input  8  OAM read data; synchronous RAM, valid the cycle after its address.
- oam_addr  output  8  OAM byte address, registered.
- oam_read_en  output  1  high while the scanner owns OAM; blocks CPU OAM access.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse when the scan completes.
- sprite_count  output  4  number of sprites selected (0..10).
- rd_index  input  4  result buffer read index (fetcher side).
- rd_valid  output  1  rd_index < sprite_count.
- rd_x  output  8  X byte of the selected entry.
- rd_oam_index  output  6  OAM entry number (0..39) of the selected entry.
- rd_row  output  4  sprite row hit by ly: ly+16-Y, 0..15.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE.
  - oam_addr=0, oam_read_en=0, busy=0, done=0, sprite_count=0.
  - All buffer entries cleared.
  - Reset mid-scan aborts immediately; there is no partial result.
- States are IDLE, SCAN, DRAIN.
- IDLE, start=1 at edge E0:
  - Latch ly and tall_sprites; clear sprite_count.
  - Enter SCAN; busy=1, oam_read_en=1.
- SCAN, cycle c = 1..80 after E0:
  - oam_addr = 4*n + p, where n = (c-1)>>1 and p = (c-1)&1.
  - Sequence: 0x00, 0x01, 0x04, 0x05, ..., 0x9C, 0x9D. Byte 0 is Y, byte 1 is X; bytes 2..3 are not read.
- Data pipeline:
  - oam_data_in sampled at the end of cycle c+1 belongs to the address driven in cycle c.
  - Y data is held in a register. The X data cycle performs the hit test and commit.
- Hit test, 9-bit unsigned arithmetic:
  - L = ly_q + 16; h = 16 if tall_q else 8.
  - Hit iff L >= Y and L < Y + h.
  - Y=0 never hits; Y >= 160 hits only where arithmetic allows.
- Commit on hit with sprite_count < MAX_SPRITES:
  - Write buffer[sprite_count] = {X, n, (L-Y)[3:0]}.
  - Increment sprite_count.
  - Hits after the buffer is full are dropped; OAM order is kept, so the lowest 10 indices win.
- DRAIN:
  - Entered after cycle 80.
  - Cycle 81: oam_read_en=0, oam_addr=0; final X data sampled and committed.
- Completion, cycle 82: state=IDLE, busy=0, done=1 for exactly one cycle.
  - sprite_count and buffer stay stable until the next accepted start.
- start while busy (SCAN or DRAIN) is ignored. start in the done cycle is accepted (state is IDLE).
- Read port is combinational from rd_index:
  - rd_index >= sprite_count (including >= 10) gives rd_valid=0 and rd_x, rd_oam_index, rd_row all 0.
  - Contents are undefined to readers while busy=1; rd_valid still follows the live sprite_count.
- ly and tall_sprites changes during a scan have no effect, because the latched copies are used.

Test Plan:
- All 160 OAM bytes 0x00, ly=0, start -> oam_addr sequence 0x00, 0x01, 0x04, ..., 0x9D over cycles 1..80; busy high cycles 1..81; done pulse cycle 82; sprite_count=0; rd_valid=0 for every rd_index.
- Entry 3: Y=0x10, X=0x08; ly=0, tall=0 -> sprite_count=1; rd_index=0 gives rd_x=0x08, rd_oam_index=3, rd_row=0; rd_index=1 gives rd_valid=0.
- Entries 0..11: Y=0x10, X=n; ly=5 -> sprite_count=10; rd_oam_index 0..9, rd_row=5 each; entries 10 and 11 dropped.
- Entry 0 Y=0x10; tall=0: ly=7 hits with row 7, ly=8 gives count 0. tall=1: ly=12 hits with row 12, ly=15 hits with row 15, ly=16 gives count 0.
- start pulsed again at cycle 40 of a scan -> ignored; done still at cycle 82 and result unchanged. Separate run: reset_n=0 at cycle 30 -> immediately busy=0, oam_read_en=0, sprite_count=0.
- Back-to-back: start in the done cycle with ly changed from 0 to 20 and Y=0x24 at entry 0 -> new scan begins next cycle; sprite_count resets to 0, then ends at 1 with rd_row=0.
